instr_mem_loader: RTL and testbench

- Writer side of the instruction path. It receives a serial byte stream from the UART receive front end and assembles 32-bit MIPS instruction words, big-endian with the first byte as the MSB.
- It writes each word into instruction memory at sequential word addresses, starting at 0.
- Loading ends when the HALT word (opcode 000000, function 111111) has been written. Overflow of memory depth is flagged.
- It feeds the instruction memory that the fetch stage and control decode later read.

---
 rtl/instr_mem_loader_if.sv | 38 +++
 rtl/instr_mem_loader.sv | 133 +++++++++++++
 tb/tb_instr_mem_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Handshake bundle between the UART byte source and the instruction loader.
//   i_start      : one-cycle pulse that begins or restarts a load
//   i_rx_valid   : i_rx_data carries a received byte this cycle
//   i_rx_data    : received byte
//   o_wr_en      : instruction-memory write strobe, one cycle per word
//   o_wr_addr    : word address of the write
//   o_wr_data    : assembled instruction word
//   o_busy       : load in progress
//   o_done       : HALT word written, held until the next i_start
//   o_overflow   : memory filled without HALT, held until the next i_start
//   o_word_count : words written in the current load
// master = byte source / host side, slave = loader side.
interface instr_mem_loader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_INST = 32,
  parameter int NB_ADDR = 8
);
  logic               i_start;
  logic               i_rx_valid;
  logic [NB_DATA-1:0] i_rx_data;
  logic               o_wr_en;
  logic [NB_ADDR-1:0] o_wr_addr;
  logic [NB_INST-1:0] o_wr_data;
  logic               o_busy;
  logic               o_done;
  logic               o_overflow;
  logic [NB_ADDR:0]   o_word_count;

  modport master (
    output i_start, i_rx_valid, i_rx_data,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow, o_word_count
  );

  modport slave (
    input  i_start, i_rx_valid, i_rx_data,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overflow, o_word_count
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: assembles big-endian 32-bit words from a byte
// stream (first byte = MSB) and writes them to sequential word addresses
// starting at 0. Loading ends once the HALT word has been written; running
// past the last address without a HALT raises o_overflow.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : instr_mem_loader_if.slave (start/byte input, write port, status)
module instr_mem_loader #(
  parameter int                 NB_DATA   = 8,
  parameter int                 NB_INST   = 32,
  parameter int                 NB_ADDR   = 8,
  parameter logic [NB_INST-1:0] HALT_INST = 32'h0000003F
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  instr_mem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [NB_ADDR-1:0] ADDR_ONE = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   CNT_ONE  = {{NB_ADDR{1'b0}}, 1'b1};

  state_t             state, state_n;
  logic [NB_INST-1:0] word, word_n;
  logic [1:0]         byte_cnt, byte_cnt_n;
  logic [NB_ADDR-1:0] addr, addr_n;
  logic [NB_ADDR:0]   word_count, word_count_n;
  logic [NB_ADDR-1:0] wr_addr, wr_addr_n;
  logic [NB_INST-1:0] wr_data, wr_data_n;
  logic [NB_INST-1:0] word_shift;

  assign word_shift = {word[NB_INST-NB_DATA-1:0], bus.i_rx_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      word       <= '0;
      byte_cnt   <= '0;
      addr       <= '0;
      word_count <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_n;
      word       <= word_n;
      byte_cnt   <= byte_cnt_n;
      addr       <= addr_n;
      word_count <= word_count_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
    end
  end

  always_comb begin
    state_n      = state;
    word_n       = word;
    byte_cnt_n   = byte_cnt;
    addr_n       = addr;
    word_count_n = word_count;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;

    // i_start wins in every state; write-port registers are left alone so a
    // strobe already on the bus completes with its own address and data.
    if (bus.i_start) begin
      state_n      = ST_RECV;
      word_n       = '0;
      byte_cnt_n   = '0;
      addr_n       = '0;
      word_count_n = '0;
    end else begin
      case (state)
        ST_RECV: begin
          if (bus.i_rx_valid) begin
            word_n = word_shift;
            if (byte_cnt == 2'd3) begin
              // Write-port registers load on the accepting edge so the
              // strobe appears in the very next cycle.
              byte_cnt_n = '0;
              wr_addr_n  = addr;
              wr_data_n  = word_shift;
              state_n    = ST_WRITE;
            end else begin
              byte_cnt_n = byte_cnt + 2'd1;
            end
          end
        end

        ST_WRITE: begin
          word_count_n = word_count + CNT_ONE;
          if (word == HALT_INST) begin
            state_n = ST_DONE;
          end else if (addr == '1) begin
            state_n = ST_ERR;
          end else begin
            addr_n  = addr + ADDR_ONE;
            state_n = ST_RECV;
            // A byte arriving during the strobe starts the next word.
            if (bus.i_rx_valid) begin
              word_n     = word_shift;
              byte_cnt_n = 2'd1;
            end
          end
        end

        ST_IDLE, ST_DONE, ST_ERR: begin
          state_n = state;
        end

        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_wr_en      = (state == ST_WRITE);
  assign bus.o_wr_addr    = wr_addr;
  assign bus.o_wr_data    = wr_data;
  assign bus.o_busy       = (state == ST_RECV) || (state == ST_WRITE);
  assign bus.o_done       = (state == ST_DONE);
  assign bus.o_overflow   = (state == ST_ERR);
  assign bus.o_word_count = word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
  localparam int          NA    = 2;
  localparam int          DEPTH = 1 << NA;
  localparam logic [31:0] HALT  = 32'h0000003F;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.NB_DATA(8), .NB_INST(32), .NB_ADDR(NA)) bus ();

  instr_mem_loader #(
    .NB_DATA  (8),
    .NB_INST  (32),
    .NB_ADDR  (NA),
    .HALT_INST(32'h0000003F)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // write monitor
  logic [NA-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.o_wr_en === 1'b1) begin
      log_addr.push_back(bus.o_wr_addr);
      log_data.push_back(bus.o_wr_data);
    end
  end

  function automatic logic [63:0] log_a(int i);
    return (i < log_addr.size()) ? 64'(log_addr[i]) : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction
  function automatic logic [63:0] log_d(int i);
    return (i < log_data.size()) ? 64'(log_data[i]) : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---- reference model: bytes collected in a queue, words emitted as writes
  bit          m_active, m_wr, m_done, m_ovf;
  logic [7:0]  m_q[$];
  int          m_addr, m_count;
  logic [31:0] m_wr_data;
  int          m_wr_addr;

  function automatic void model_reset();
    m_active = 0; m_wr = 0; m_done = 0; m_ovf = 0;
    m_q.delete();
    m_addr = 0; m_count = 0; m_wr_data = '0; m_wr_addr = 0;
  endfunction

  function automatic void model_edge(bit start, bit valid, logic [7:0] data);
    if (start) begin
      m_q.delete();
      m_addr = 0; m_count = 0; m_done = 0; m_ovf = 0;
      m_active = 1; m_wr = 0;
    end else if (m_wr) begin
      m_wr = 0;
      m_count++;
      if (m_wr_data == HALT) begin
        m_done = 1; m_active = 0;
      end else if (m_addr == DEPTH - 1) begin
        m_ovf = 1; m_active = 0;
      end else begin
        m_addr++;
        if (valid) m_q.push_back(data);
      end
    end else if (m_active && valid) begin
      m_q.push_back(data);
      if (m_q.size() == 4) begin
        m_wr_data = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_wr_addr = m_addr;
        m_wr      = 1;
        m_q.delete();
      end
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, " wr_en"},    bus.o_wr_en,      m_wr);
    check({tag, " wr_addr"},  bus.o_wr_addr,    m_wr_addr);
    check({tag, " wr_data"},  bus.o_wr_data,    m_wr_data);
    check({tag, " busy"},     bus.o_busy,       m_active);
    check({tag, " done"},     bus.o_done,       m_done);
    check({tag, " overflow"}, bus.o_overflow,   m_ovf);
    check({tag, " count"},    bus.o_word_count, m_count);
  endtask

  // ---- stimulus helpers
  task automatic step(input bit start, input bit valid, input logic [7:0] data);
    @(negedge clk);
    bus.i_start    = start;
    bus.i_rx_valid = valid;
    bus.i_rx_data  = data;
    @(posedge clk);
    #1;
    model_edge(start, valid, data);
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, w[31-8*i -: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          start;
    bit          valid;
    logic [7:0]  data;
    bit          wr_en;
    logic [NA-1:0] addr;
    logic [31:0] wdata;
    bit          busy;
    bit          done;
    bit          ovf;
    logic [NA:0] cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  plan[$];
    logic [31:0] w;
    bit          st, v;
    logic [7:0]  d;

    // basic load with gaps: start, 00 22 18 21, 00 00 00 3F, then an ignored byte
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'h18, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0};
    tbl[6]  = '{1'b0, 1'b1, 8'h21, 1'b1, 2'd0, 32'h00221821, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 32'h00221821, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 32'h00221821, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 32'h00221821, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 32'h00221821, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 32'h00221821, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[12] = '{1'b0, 1'b1, 8'h3F, 1'b1, 2'd1, 32'h0000003F, 1'b1, 1'b0, 1'b0, 3'd1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 32'h0000003F, 1'b0, 1'b1, 1'b0, 3'd2};
    tbl[14] = '{1'b0, 1'b1, 8'hAA, 1'b0, 2'd1, 32'h0000003F, 1'b0, 1'b1, 1'b0, 3'd2};

    rst_n          = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset in the middle of a word
    step(1'b1, 1'b0, 8'h00);
    send_word(32'h11223344);
    idle(1);
    check("pre-reset count", bus.o_word_count, 1);
    step(1'b0, 1'b1, 8'h55);
    step(1'b0, 1'b1, 8'h66);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    log_addr.delete(); log_data.delete();
    step(1'b1, 1'b0, 8'h00);
    send_word(32'h00221821);
    idle(1);
    check("after reset writes", log_addr.size(), 1);
    check("after reset addr", log_a(0), 0);
    check("after reset data", log_d(0), 32'h00221821);

    // table-driven basic load
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].start, tbl[i].valid, tbl[i].data);
      check($sformatf("vec%0d wr_en", i),   bus.o_wr_en,      tbl[i].wr_en);
      check($sformatf("vec%0d wr_addr", i), bus.o_wr_addr,    tbl[i].addr);
      check($sformatf("vec%0d wr_data", i), bus.o_wr_data,    tbl[i].wdata);
      check($sformatf("vec%0d busy", i),    bus.o_busy,       tbl[i].busy);
      check($sformatf("vec%0d done", i),    bus.o_done,       tbl[i].done);
      check($sformatf("vec%0d overflow", i), bus.o_overflow,  tbl[i].ovf);
      check($sformatf("vec%0d count", i),   bus.o_word_count, tbl[i].cnt);
    end

    // back-to-back bytes, third word is HALT
    log_addr.delete(); log_data.delete();
    step(1'b1, 1'b0, 8'h00);
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    send_word(HALT);
    idle(2);
    check("b2b writes", log_addr.size(), 3);
    check("b2b addr0", log_a(0), 0);
    check("b2b data0", log_d(0), 32'h12345678);
    check("b2b addr1", log_a(1), 1);
    check("b2b data1", log_d(1), 32'h9ABCDEF0);
    check("b2b addr2", log_a(2), 2);
    check("b2b data2", log_d(2), HALT);
    check("b2b done", bus.o_done, 1);
    check("b2b count", bus.o_word_count, 3);

    // overflow: four non-HALT words fill the 4-word memory
    log_addr.delete(); log_data.delete();
    step(1'b1, 1'b0, 8'h00);
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'h090A0B0C);
    send_word(32'h0D0E0F10);
    step(1'b0, 1'b1, 8'hEE);
    step(1'b0, 1'b1, 8'hDD);
    idle(2);
    check("ovf writes", log_addr.size(), 4);
    check("ovf addr3", log_a(3), 3);
    check("ovf data3", log_d(3), 32'h0D0E0F10);
    check("ovf flag", bus.o_overflow, 1);
    check("ovf done", bus.o_done, 0);
    check("ovf busy", bus.o_busy, 0);
    check("ovf count", bus.o_word_count, 4);

    // restart after one word plus two bytes
    log_addr.delete(); log_data.delete();
    step(1'b1, 1'b0, 8'h00);
    send_word(32'hAABBCCDD);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b1, 1'b0, 8'h00);
    send_word(32'hCAFEF00D);
    idle(1);
    check("restart writes", log_addr.size(), 2);
    check("restart addr", log_a(1), 0);
    check("restart data", log_d(1), 32'hCAFEF00D);
    check("restart count", bus.o_word_count, 1);
    check("restart busy", bus.o_busy, 1);

    // HALT at the last address
    log_addr.delete(); log_data.delete();
    step(1'b1, 1'b0, 8'h00);
    send_word(32'h20010001);
    send_word(32'h20020002);
    send_word(32'h20030003);
    send_word(HALT);
    idle(1);
    check("halt-last writes", log_addr.size(), 4);
    check("halt-last addr", log_a(3), 3);
    check("halt-last data", log_d(3), HALT);
    check("halt-last done", bus.o_done, 1);
    check("halt-last overflow", bus.o_overflow, 0);
    check("halt-last count", bus.o_word_count, 4);

    // bytes after done and before start are ignored
    log_addr.delete(); log_data.delete();
    send_word(32'h01020304);
    idle(1);
    check("guard done writes", log_addr.size(), 0);
    check("guard done count", bus.o_word_count, 4);
    check("guard done flag", bus.o_done, 1);
    do_reset();
    send_word(32'h05060708);
    idle(1);
    check("guard idle writes", log_addr.size(), 0);
    check("guard idle count", bus.o_word_count, 0);
    check("guard idle busy", bus.o_busy, 0);

    // randomized stream against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (plan.size() == 0) begin
        w = ($urandom_range(0, 3) == 0) ? HALT : 32'($urandom);
        for (int b = 0; b < 4; b++) plan.push_back(w[31-8*b -: 8]);
      end
      st = ($urandom_range(0, 59) == 0) || ((m_done || m_ovf) && $urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 9) < 7);
      d  = plan[0];
      if (v) void'(plan.pop_front());
      step(st, v, d);
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
